// File: rtl/vx_tcu_drl_cval_align.sv
// vx_tcu_drl_cval_align: unpacks the FP32/INT32 C accumulator operand and aligns
// it into the shared two's-complement accumulator format relative to max_exp.
// Two-stage valid/ready pipeline: S1 unpacks, S2 aligns and holds the output beat.

package vx_tcu_drl_cval_align_pkg;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic sign;
    } fedp_excep_t;

endpackage

module vx_tcu_drl_cval_align
    import vx_tcu_drl_cval_align_pkg::*;
#(
    parameter int N      = 5,
    parameter int W      = 25,
    parameter int WA     = 30,
    parameter int EXP_W  = 10,
    parameter int C_HI_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [31:0]       req_id,
    input  logic [31:0]       c_val,
    input  logic              is_int,
    input  logic [EXP_W-1:0]  max_exp,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [31:0]       req_id_out,
    output logic [WA-1:0]     acc_sig,
    output logic [C_HI_W-1:0] cval_hi,
    output logic              sticky_out,
    output logic              ovf_out,
    output fedp_excep_t       excep_out
);

    // Exponent difference is carried one bit wider than max_exp so that
    // eff_e - 23 - max_exp never wraps for any legal max_exp.
    localparam int DW = EXP_W + 1;

    typedef struct packed {
        logic          sign;
        logic [23:0]   mant;
        logic [DW-1:0] dexp;
        logic          is_nan;
        logic          is_inf;
        logic          is_int;
        logic [31:0]   cval;
        logic [31:0]   id;
    } s1_pay_t;

    typedef struct packed {
        logic [31:0]       id;
        logic [WA-1:0]     acc;
        logic [C_HI_W-1:0] hi;
        logic              sticky;
        logic              ovf;
        fedp_excep_t       excep;
    } s2_pay_t;

    logic    s1_valid_d, s1_valid_q;
    logic    s2_valid_d, s2_valid_q;
    s1_pay_t s1_pay_d, s1_pay_q;
    s2_pay_t s2_pay_d, s2_pay_q;
    s1_pay_t unpack;
    s2_pay_t aligned;
    logic    s1_load, s2_load;

    logic [7:0]           exp_field;
    logic [22:0]          frac_field;
    logic [7:0]           eff_e;
    logic [DW-1:0]        shift_k;
    logic [WA-1:0]        mag;

    // Pipeline flow control: S2 frees up when empty or retiring, S1 follows S2.
    always_comb begin
        s2_load  = !s2_valid_q || ready_out;
        s1_load  = !s1_valid_q || s2_load;
        ready_in = s1_load;
    end

    // Stage 1 unpack: classify the FP32 pattern and compute the alignment distance.
    always_comb begin
        exp_field   = c_val[30:23];
        frac_field  = c_val[22:0];
        unpack      = '0;
        unpack.sign = c_val[31];
        if (exp_field == 8'd0) begin
            unpack.mant = {1'b0, frac_field};
            eff_e       = 8'd1;
        end else begin
            unpack.mant = {1'b1, frac_field};
            eff_e       = exp_field;
        end
        unpack.is_nan = (exp_field == 8'hFF) && (frac_field != 23'd0);
        unpack.is_inf = (exp_field == 8'hFF) && (frac_field == 23'd0);
        unpack.dexp   = {{(DW-8){1'b0}}, eff_e} - DW'(23)
                      - {max_exp[EXP_W-1], max_exp};
        unpack.is_int = is_int;
        unpack.cval   = c_val;
        unpack.id     = req_id;
    end

    // Stage 1 register next-state: capture a new request whenever S1 can load.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pay_d   = s1_pay_q;
        if (s1_load) begin
            s1_valid_d = valid_in;
            if (valid_in) begin
                s1_pay_d = unpack;
            end
        end
    end

    // Stage 2 align: shift the significand to the accumulator grid and apply sign.
    always_comb begin
        aligned    = '0;
        aligned.id = s1_pay_q.id;
        mag        = '0;
        shift_k    = -s1_pay_q.dexp;
        if (s1_pay_q.is_int) begin
            aligned.acc = {{(WA-W){1'b0}}, s1_pay_q.cval[W-1:0]};
            aligned.hi  = C_HI_W'($signed(s1_pay_q.cval[31:W]));
        end else if (s1_pay_q.is_nan || s1_pay_q.is_inf) begin
            aligned.excep.is_nan = s1_pay_q.is_nan;
            aligned.excep.is_inf = s1_pay_q.is_inf;
            aligned.excep.sign   = s1_pay_q.sign;
        end else begin
            aligned.excep.sign = s1_pay_q.sign;
            if (!s1_pay_q.dexp[DW-1]) begin
                if (s1_pay_q.dexp > DW'(WA - 25)) begin
                    aligned.ovf = 1'b1;
                end else begin
                    mag = WA'(s1_pay_q.mant) << s1_pay_q.dexp;
                end
            end else if (shift_k < DW'(24)) begin
                mag            = WA'(s1_pay_q.mant >> shift_k);
                aligned.sticky = |(s1_pay_q.mant & ~({24{1'b1}} << shift_k));
            end else begin
                aligned.sticky = |s1_pay_q.mant;
            end
            aligned.acc = s1_pay_q.sign ? (~mag + WA'(1)) : mag;
        end
    end

    // Stage 2 register next-state: outputs only change when the held beat retires.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_pay_d   = s2_pay_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pay_d = aligned;
            end
        end
    end

    // State registers; reset discards any in-flight beats and clears the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_pay_q   <= '0;
            s2_pay_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_pay_q   <= s1_pay_d;
            s2_pay_q   <= s2_pay_d;
        end
    end

    // Output beat comes straight from the stage 2 register.
    always_comb begin
        valid_out  = s2_valid_q;
        req_id_out = s2_pay_q.id;
        acc_sig    = s2_pay_q.acc;
        cval_hi    = s2_pay_q.hi;
        sticky_out = s2_pay_q.sticky;
        ovf_out    = s2_pay_q.ovf;
        excep_out  = s2_pay_q.excep;
    end

endmodule

// File: tb/tb_vx_tcu_drl_cval_align.sv
// tb_vx_tcu_drl_cval_align: directed scoreboard bench for the C-operand align stage.
module tb_vx_tcu_drl_cval_align;
    import vx_tcu_drl_cval_align_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] req_id;
    logic [31:0] c_val;
    logic        is_int;
    logic [9:0]  max_exp;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] req_id_out;
    logic [29:0] acc_sig;
    logic [7:0]  cval_hi;
    logic        sticky_out;
    logic        ovf_out;
    fedp_excep_t excep_out;

    typedef struct {
        logic [31:0] id;
        logic [29:0] acc;
        logic [7:0]  hi;
        logic        st;
        logic        ovf;
        logic [2:0]  exc;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   retired = 0;

    vx_tcu_drl_cval_align dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .req_id     (req_id),
        .c_val      (c_val),
        .is_int     (is_int),
        .max_exp    (max_exp),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .req_id_out (req_id_out),
        .acc_sig    (acc_sig),
        .cval_hi    (cval_hi),
        .sticky_out (sticky_out),
        .ovf_out    (ovf_out),
        .excep_out  (excep_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Retire side: every beat leaving the DUT is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && valid_out === 1'b1 && ready_out === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("[TB] FAIL unexpected_beat got id=%0h want none", req_id_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("req_id_out", 64'(req_id_out), 64'(e.id));
                check_output("acc_sig",    64'(acc_sig),    64'(e.acc));
                check_output("cval_hi",    64'(cval_hi),    64'(e.hi));
                check_output("sticky",     64'(sticky_out), 64'(e.st));
                check_output("ovf",        64'(ovf_out),    64'(e.ovf));
                check_output("excep",      64'(excep_out),  64'(e.exc));
                retired++;
            end
        end
    end

    // Drive one request (caller sits just after a rising edge) and queue its expectation on accept.
    task automatic apply_stimulus(input logic [31:0] id, input logic [31:0] cv, input logic ii,
                                  input logic [9:0] me, input logic [29:0] acc, input logic [7:0] hi,
                                  input logic st, input logic ov, input logic [2:0] exc);
        int   waited = 0;
        exp_t e;
        valid_in = 1'b1;
        req_id   = id;
        c_val    = cv;
        is_int   = ii;
        max_exp  = me;
        @(negedge clk);
        while (ready_in !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (ready_in !== 1'b1) begin
            total++;
            bad++;
            $error("[TB] FAIL accept_timeout got ready_in=%b want 1 id=%0h", ready_in, id);
        end else begin
            e.id = id; e.acc = acc; e.hi = hi; e.st = st; e.ovf = ov; e.exc = exc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || valid_out === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("[TB] FAIL drain_timeout got pending=%0d want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        reset_n   = 1'b0;
        valid_in  = 1'b0;
        req_id    = '0;
        c_val     = '0;
        is_int    = 1'b0;
        max_exp   = '0;
        ready_out = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_valid_out", 64'(valid_out),  64'd0);
        check_output("rst_ready_in",  64'(ready_in),   64'd1);
        check_output("rst_acc_sig",   64'(acc_sig),    64'd0);
        check_output("rst_req_id",    64'(req_id_out), 64'd0);
        check_output("rst_cval_hi",   64'(cval_hi),    64'd0);
        check_output("rst_flags",     64'({sticky_out, ovf_out, excep_out}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // First beat with latency check: 1.0 at max_exp 104 lands on bit 23
        apply_stimulus(32'h1, 32'h3F800000, 1'b0, 10'd104, 30'h0800000, 8'h00, 1'b0, 1'b0, 3'b000);
        valid_in = 1'b0;
        @(negedge clk);
        check_output("lat_one_cycle", 64'(valid_out), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("lat_two_cycle", 64'(valid_out), 64'd1);
        @(posedge clk); #1;
        wait_drain(20);

        // Directed FP/INT patterns, one at a time
        apply_stimulus(32'h2,  32'hBF800000, 1'b0, 10'd104, 30'h3F800000, 8'h00, 1'b0, 1'b0, 3'b001);
        apply_stimulus(32'h3,  32'h3F800001, 1'b0, 10'd110, 30'h0020000,  8'h00, 1'b1, 1'b0, 3'b000);
        apply_stimulus(32'h4,  32'hBF800001, 1'b0, 10'd110, 30'h3FFE0000, 8'h00, 1'b1, 1'b0, 3'b001);
        apply_stimulus(32'h5,  32'h3F800000, 1'b0, 10'd90,  30'h0,        8'h00, 1'b0, 1'b1, 3'b000);
        apply_stimulus(32'h6,  32'h3F800000, 1'b0, 10'd99,  30'h10000000, 8'h00, 1'b0, 1'b0, 3'b000);
        apply_stimulus(32'h7,  32'h3F800000, 1'b0, 10'd98,  30'h0,        8'h00, 1'b0, 1'b1, 3'b000);
        apply_stimulus(32'h8,  32'h3F800000, 1'b0, 10'd127, 30'h1,        8'h00, 1'b0, 1'b0, 3'b000);
        apply_stimulus(32'h9,  32'h3F800000, 1'b0, 10'd128, 30'h0,        8'h00, 1'b1, 1'b0, 3'b000);
        apply_stimulus(32'hA,  32'h3F800000, 1'b0, 10'd140, 30'h0,        8'h00, 1'b1, 1'b0, 3'b000);
        apply_stimulus(32'hB,  32'h00000001, 1'b0, 10'h3EA, 30'h1,        8'h00, 1'b0, 1'b0, 3'b000);
        apply_stimulus(32'hC,  32'h80000000, 1'b0, 10'd104, 30'h0,        8'h00, 1'b0, 1'b0, 3'b001);
        apply_stimulus(32'hD,  32'h7FC00000, 1'b0, 10'd104, 30'h0,        8'h00, 1'b0, 1'b0, 3'b100);
        apply_stimulus(32'hE,  32'hFF800000, 1'b0, 10'd104, 30'h0,        8'h00, 1'b0, 1'b0, 3'b011);
        apply_stimulus(32'hF,  32'hFFFFFFFE, 1'b1, 10'd104, 30'h1FFFFFE,  8'hFF, 1'b0, 1'b0, 3'b000);
        apply_stimulus(32'h10, 32'h12345678, 1'b1, 10'd0,   30'h0345678,  8'h09, 1'b0, 1'b0, 3'b000);
        valid_in = 1'b0;
        wait_drain(40);

        // Backpressure: four beats streamed while the output is stalled
        base      = retired;
        ready_out = 1'b0;
        fork
            begin
                apply_stimulus(32'd100, 32'h3F800000, 1'b0, 10'd104, 30'h0800000,  8'h00, 1'b0, 1'b0, 3'b000);
                apply_stimulus(32'd101, 32'h40000000, 1'b0, 10'd104, 30'h1000000,  8'h00, 1'b0, 1'b0, 3'b000);
                apply_stimulus(32'd102, 32'h3F000000, 1'b0, 10'd104, 30'h0400000,  8'h00, 1'b0, 1'b0, 3'b000);
                apply_stimulus(32'd103, 32'hBF800000, 1'b0, 10'd104, 30'h3F800000, 8'h00, 1'b0, 1'b0, 3'b001);
                valid_in = 1'b0;
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (valid_out !== 1'b1 && n < 20);
                for (int c = 0; c < 3; c++) begin
                    check_output("stall_valid",    64'(valid_out),  64'd1);
                    check_output("stall_hold_id",  64'(req_id_out), 64'd100);
                    check_output("stall_hold_acc", 64'(acc_sig),    64'h0800000);
                    check_output("stall_ready_in", 64'(ready_in),   64'd0);
                    if (c < 2) @(negedge clk);
                end
                @(posedge clk); #1;
                ready_out = 1'b1;
            end
        join
        wait_drain(40);
        check_output("stream_count", 64'(retired - base), 64'd4);

        // Reset with beats in flight: everything is discarded
        apply_stimulus(32'd200, 32'h3F800000, 1'b0, 10'd104, 30'h0800000, 8'h00, 1'b0, 1'b0, 3'b000);
        apply_stimulus(32'd201, 32'h40000000, 1'b0, 10'd104, 30'h1000000, 8'h00, 1'b0, 1'b0, 3'b000);
        valid_in = 1'b0;
        reset_n  = 1'b0;
        sb.delete();
        @(negedge clk);
        check_output("midrst_valid",    64'(valid_out), 64'd0);
        check_output("midrst_ready_in", 64'(ready_in),  64'd1);
        check_output("midrst_acc",      64'(acc_sig),   64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_output("post_rst_idle", 64'(valid_out), 64'd0);
        end
        @(posedge clk); #1;

        // Recovery after reset
        apply_stimulus(32'd300, 32'hFFFFFFFE, 1'b1, 10'd0, 30'h1FFFFFE, 8'hFF, 1'b0, 1'b0, 3'b000);
        valid_in = 1'b0;
        wait_drain(20);
        check_output("final_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_tcu_drl_cval_align.md
Name: vx_tcu_drl_cval_align

Overview:
- Input-side counterpart of the FEDP normalize/round stage. Unpacks the FP32 (or INT32) C accumulator operand and denormalizes/aligns it into the shared WA-bit two's-complement accumulator format, referenced to the dot-product max_exp.
- Also emits sticky, exception flags and the integer high slice (cval_hi) consumed by the final int adder.
- 2-stage valid/ready pipeline between the C-operand fetch and the FEDP accumulator adder.

Parameters:
- N, 5, FEDP lane count (passed through; used only for trace id width consistency).
- W, 25, shared low-accumulator width for integer mode.
- WA, 30, accumulator width (two's complement).
- EXP_W, 10, signed exponent width of max_exp.
- C_HI_W, 8, integer high-slice width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- valid_in  in  1  request valid.
- ready_in  out  1  stage can accept a request.
- req_id  in  32  request tag, passed through.
- c_val  in  32  FP32 bit pattern, or INT32 when is_int.
- is_int  in  1  integer mode.
- max_exp  in  EXP_W  signed biased exponent; accumulator bit i weighs 2^(max_exp-127+i).
- valid_out  out  1  result valid.
- ready_out  in  1  downstream accepts.
- req_id_out  out  32  tag of the output beat.
- acc_sig  out  WA  aligned two's-complement addend.
- cval_hi  out  C_HI_W  integer high slice (0 in FP mode).
- sticky_out  out  1  OR of magnitude bits shifted below bit 0.
- ovf_out  out  1  aligned magnitude does not fit in WA-1 bits.
- excep_out  out  fedp_excep_t  {is_nan, is_inf, sign} of C.

Behaviour:
- Reset (async assert, sync deassert at clk): both stage valids 0. All outputs 0, ready_in=1.
- Stage S1 (unpack):
  - s=c_val[31], e=c_val[30:23], f=c_val[22:0].
  - Class: e=255, f!=0 -> NaN; e=255, f=0 -> Inf.
  - e=0 -> subnormal/zero: m={0,f}, eff_e=1. Otherwise m={1,f}, eff_e=e.
  - d = eff_e - 23 - max_exp, signed EXP_W+1 bits.
  - Register s, m, d, class, is_int, c_val, req_id.
- Stage S2 (align):
  - d>=0: mag = m<<d. ovf=1 if d > WA-25, then acc_sig = 0.
  - d<0, k=-d: k<24 -> mag = m>>k, sticky = |m[k-1:0]; k>=24 -> mag = 0, sticky = |m.
  - acc_sig = s ? -mag : mag, WA bits. Zero input gives acc_sig=0 for either sign.
  - NaN/Inf: acc_sig=0, sticky=0, excep set with sign=s.
  - is_int: acc_sig = {(WA-W) zeros, c_val[W-1:0]}; cval_hi = sign-extend c_val[31:W] to C_HI_W; sticky/ovf/excep = 0.
- Handshake:
  - Beat transfers when valid && ready.
  - S2 loads when S2 empty or ready_out. S1 loads when S1 empty or S2 loads.
  - ready_in = !s1_valid || s2_load (combinational from ready_out).
  - Latency: 2 cycles under no backpressure; throughput 1/cycle.
  - Outputs are held stable while valid_out && !ready_out.
  - Never drop or duplicate a beat. Simultaneous input accept and output retire in the same cycle is legal.
- Reset mid-operation discards all in-flight beats; no output follows.

Test Plan:
- c_val=0x3F800000 (1.0), max_exp=104, fp -> 2 cycles later acc_sig=0x0800000, sticky=0, ovf=0, excep=0.
- c_val=0xBF800000, max_exp=104 -> acc_sig=0x3F800000 (30-bit -0x800000). c_val=0x3F800001, max_exp=110 -> acc_sig=0x20000, sticky=1.
- c_val=0x3F800000, max_exp=90 (d=14) -> ovf=1, acc_sig=0. c_val=0x3F800000, max_exp=140 (k=36) -> acc_sig=0, sticky=1.
- c_val=0x7FC00000 -> excep.is_nan=1. c_val=0xFF800000 -> is_inf=1, sign=1, acc_sig=0.
- is_int=1, c_val=0xFFFFFFFE -> acc_sig=0x1FFFFFE, cval_hi=0xFF, sticky=0.
- Stream 4 beats, hold ready_out=0 for 3 cycles after the first output -> ready_in drops once both stages are full; outputs held. On release, all 4 beats emerge in order with correct req_id_out. Assert reset_n mid-stream -> valid_out=0 next edge, no stale beat.
